// File: rtl/e_md_unit.sv
// E-stage multiply/divide unit with HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU for a fixed number of busy cycles and writes HI/LO when the count expires.
module e_md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_md_op,
  input  logic        E_md_start,
  input  logic [31:0] E_V1,
  input  logic [31:0] E_V2,
  input  logic        D_md_use,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic        md_busy,
  output logic        md_stall
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic [31:0]   hi, hi_n, lo, lo_n;
  logic          latch;
  logic          long_start;

  logic [63:0]   prod_s, prod_u;
  logic          signed_div, neg_q, neg_r;
  logic [31:0]   da, db, q_mag, r_mag, q_res, r_res;

  assign long_start = E_md_start && (E_md_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
  assign md_busy    = (state == RUN);
  assign md_stall   = D_md_use && (md_busy || long_start);
  assign E_HI       = hi;
  assign E_LO       = lo;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide on magnitudes so MIN/-1 wraps cleanly instead of overflowing
  always_comb begin
    signed_div = (op_q == OP_DIV);
    neg_r      = signed_div && a_q[31];
    neg_q      = signed_div && (a_q[31] ^ b_q[31]);
    da         = neg_r ? (32'd0 - a_q) : a_q;
    db         = (signed_div && b_q[31]) ? (32'd0 - b_q) : b_q;
    q_mag      = 32'd0;
    r_mag      = 32'd0;
    if (db != 32'd0) begin
      q_mag = da / db;
      r_mag = da % db;
    end
    q_res = neg_q ? (32'd0 - q_mag) : q_mag;
    r_res = neg_r ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        if (E_md_start) begin
          case (E_md_op)
            OP_MULT, OP_MULTU: begin
              latch   = 1'b1;
              cnt_n   = CW'(MULT_CYCLES);
              state_n = RUN;
            end
            OP_DIV, OP_DIVU: begin
              latch   = 1'b1;
              cnt_n   = CW'(DIV_CYCLES);
              state_n = RUN;
            end
            OP_MTHI: hi_n = E_V1;
            OP_MTLO: lo_n = E_V1;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          case (op_q)
            OP_MULT:  {hi_n, lo_n} = prod_s;
            OP_MULTU: {hi_n, lo_n} = prod_u;
            OP_DIV, OP_DIVU: begin
              if (b_q != 32'd0) begin
                hi_n = r_res;
                lo_n = q_res;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      if (latch) begin
        op_q <= E_md_op;
        a_q  <= E_V1;
        b_q  <= E_V2;
      end
    end
  end

  // The hazard unit must never issue a HI/LO op while an operation is running
  a_no_start_in_run: assert property (@(posedge clk) disable iff (!reset)
    !(md_busy && E_md_start && (E_md_op inside {[3'd1:3'd6]})))
    else $warning("e_md_unit: op issued while busy was ignored");

endmodule

// File: tb/tb_e_md_unit.sv
// Directed self-checking bench for e_md_unit.
// Expected values are hand-computed constants.
module tb_e_md_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  E_md_op;
  logic        E_md_start;
  logic [31:0] E_V1;
  logic [31:0] E_V2;
  logic        D_md_use;
  logic [31:0] E_HI;
  logic [31:0] E_LO;
  logic        md_busy;
  logic        md_stall;

  int checks = 0;
  int errors = 0;

  e_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .E_md_op    (E_md_op),
    .E_md_start (E_md_start),
    .E_V1       (E_V1),
    .E_V2       (E_V2),
    .D_md_use   (D_md_use),
    .E_HI       (E_HI),
    .E_LO       (E_LO),
    .md_busy    (md_busy),
    .md_stall   (md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Drive one op for a single cycle starting at a falling edge
  task automatic drive(input logic [2:0] op, input logic [31:0] v1, input logic [31:0] v2);
    @(negedge clk);
    E_md_op    = op;
    E_md_start = 1'b1;
    E_V1       = v1;
    E_V2       = v2;
  endtask

  task automatic idle();
    @(negedge clk);
    E_md_start = 1'b0;
    E_md_op    = 3'd0;
    E_V1       = $urandom;
    E_V2       = $urandom;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] v1, input logic [31:0] v2,
                               output logic startStall);
    drive(op, v1, v2);
    #1 startStall = md_stall;
    idle();
  endtask

  // Counts busy and stalled cycles until busy drops, bounded so a stuck unit still ends the run
  task automatic waitIdle(output int busyCycles, output int stallCycles);
    busyCycles  = 0;
    stallCycles = 0;
    while (md_busy && busyCycles < 100) begin
      busyCycles++;
      if (md_stall) stallCycles++;
      @(negedge clk);
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] v1,
                       input logic [31:0] v2, input int cycles,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    logic s;
    int   b, st;
    applyStimulus(op, v1, v2, s);
    waitIdle(b, st);
    checkOutput({tag, "_busy"}, 32'(b), 32'(cycles));
    checkOutput({tag, "_hi"}, E_HI, expHi);
    checkOutput({tag, "_lo"}, E_LO, expLo);
  endtask

  initial begin
    logic s;
    int   b, st;

    reset      = 1'b0;
    E_md_op    = 3'd0;
    E_md_start = 1'b0;
    E_V1       = 32'd0;
    E_V2       = 32'd0;
    D_md_use   = 1'b0;
    #12;
    checkOutput("rst_hi", E_HI, 32'd0);
    checkOutput("rst_lo", E_LO, 32'd0);
    checkOutput("rst_busy", 32'(md_busy), 32'd0);
    checkOutput("rst_stall", 32'(md_stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    runOp("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runOp("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    runOp("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("div_7_m2", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    runOp("divu_7_2", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    runOp("div_min", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    drive(3'd5, 32'h11, 32'd0);
    drive(3'd6, 32'h22, 32'd0);
    idle();
    runOp("divu_by0", 3'd4, 32'd5, 32'd0, 10, 32'h11, 32'h22);
    runOp("div_by0", 3'd3, 32'hFFFF_FFF0, 32'd0, 10, 32'h11, 32'h22);

    D_md_use = 1'b1;
    @(negedge clk);
    checkOutput("stall_idle", 32'(md_stall), 32'd0);
    drive(3'd5, 32'h77, 32'd0);
    #1 checkOutput("stall_mthi", 32'(md_stall), 32'd0);
    idle();
    applyStimulus(3'd1, 32'd4, 32'd5, s);
    checkOutput("stall_start", 32'(s), 32'd1);
    waitIdle(b, st);
    checkOutput("stall_busy", 32'(b), 32'd5);
    checkOutput("stall_cycles", 32'(st), 32'd5);
    checkOutput("stall_done", 32'(md_stall), 32'd0);
    checkOutput("stall_lo", E_LO, 32'd20);
    D_md_use = 1'b0;
    applyStimulus(3'd1, 32'd4, 32'd5, s);
    checkOutput("nostall_start", 32'(s), 32'd0);
    waitIdle(b, st);
    checkOutput("nostall_cycles", 32'(st), 32'd0);

    drive(3'd5, 32'hABCD, 32'd0);
    drive(3'd6, 32'h1234, 32'd0);
    #1 checkOutput("mthi_busy", 32'(md_busy), 32'd0);
    idle();
    #1 checkOutput("mtlo_busy", 32'(md_busy), 32'd0);
    checkOutput("mt_hi", E_HI, 32'hABCD);
    checkOutput("mt_lo", E_LO, 32'h1234);

    applyStimulus(3'd1, 32'd2, 32'd3, s);
    drive(3'd6, 32'h5555, 32'd0);
    idle();
    checkOutput("run_mtlo_lo", E_LO, 32'h1234);
    waitIdle(b, st);
    checkOutput("run_mtlo_busy", 32'(b), 32'd3);
    checkOutput("run_mtlo_hi", E_HI, 32'd0);
    checkOutput("run_mtlo_res", E_LO, 32'd6);

    drive(3'd5, 32'h99, 32'd0);
    drive(3'd6, 32'h88, 32'd0);
    idle();
    applyStimulus(3'd4, 32'd100, 32'd7, s);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_hi", E_HI, 32'd0);
    checkOutput("midrst_lo", E_LO, 32'd0);
    checkOutput("midrst_busy", 32'(md_busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("postrst_hi", E_HI, 32'd0);
    checkOutput("postrst_lo", E_LO, 32'd0);
    checkOutput("postrst_busy", 32'(md_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
